mem_block_responder: RTL
========================

Name: mem_block_responder

Overview:
- Block-granular main-memory responder; the far end of the L2 miss/writeback interface.
- Accepts a single-cycle-or-level read/write request from the L2 controller and waits a fixed access latency.
- On a read it returns a full L2 block; on a write it commits one. Completion is signalled with a one-cycle ready/hit pulse.
- Backing store is a byte array covering the whole address space, with deterministic initial contents.

Parameters:
ADDR_WIDTH, 11, byte address width; store depth is 2^ADDR_WIDTH words.
DATA_WIDTH, 8, word (byte) width.
BLOCK_SIZE, 32, words per block; power of 2, at most 2^ADDR_WIDTH.
LATENCY, 4, cycles from request acceptance to ready; at least 1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-high.
read  in  1  read request (level).
write  in  1  write request (level).
addr  in  ADDR_WIDTH  byte address; low log2(BLOCK_SIZE) bits ignored (block-aligned).
data_in  in  BLOCK_SIZE*DATA_WIDTH  write block; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
data_out  out  BLOCK_SIZE*DATA_WIDTH  read block, same packing.
ready  out  1  one-cycle completion pulse.
hit  out  1  high with ready when the completed operation was a read (data_out valid).

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (while rst_n asserted):
  - FSM goes to IDLE; ready=0, hit=0, data_out=0, latency counter=0.
  - Store initialised so that word i = i mod 2^DATA_WIDTH.
  - Reset mid-BUSY/RESP aborts the operation. A pending write is discarded and no ready is produced.
- IDLE:
  - If write=1 at a rising edge, the request is accepted. This applies even if read=1 as well: write has priority.
  - Otherwise, if read=1, the request is accepted.
  - On acceptance: block base = addr with low bits cleared; op type and data_in are captured; counter = LATENCY-1; go to BUSY.
- BUSY:
  - Inputs are ignored; captured values are used.
  - Counter decrements each cycle. At counter==0, the operation is performed at the next edge:
    - write: all BLOCK_SIZE words are stored at base+k.
    - read: data_out is loaded from words base+k.
  - Then go to RESP.
- RESP:
  - ready=1 for exactly one cycle.
  - hit=1 iff the op was a read.
  - Next state is IDLE.
- Timing: a request sampled at edge N gives ready=1 during the cycle after edge N+LATENCY. With LATENCY=1, ready is seen one cycle after acceptance.
- data_out holds its last read value until the next read completes. Writes do not alter data_out.
- Back-to-back: a request still asserted in IDLE after RESP is accepted again as a new operation. The requester must drop read/write on seeing ready.
- Addressing: no wrap within a block, because bases are aligned. The highest block is base 2^ADDR_WIDTH-BLOCK_SIZE.
- Write-then-read to the same block: the read returns the written data, since the write commits before RESP.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined, add outputs:
  - rd_count [31:0]: increments by 1 in each RESP cycle for a read.
  - wr_count [31:0]: increments by 1 in each RESP cycle for a write.
  - Both counters are cleared by reset and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Read latency/data, defaults: read=1, addr=0x045 at edge N.
  - ready=1 and hit=1 for exactly one cycle after edge N+4.
  - data_out word k = 0x40+k (0x40..0x5F).
- Write then read: write=1, addr=0x100, data_in all words 0xA5.
  - After the write: ready=1, hit=0, data_out unchanged.
  - Then read addr=0x11F: data_out is all words 0xA5.
- Simultaneous read=1, write=1: addr=0x020, data_in words 0x3C.
  - Treated as write: hit=0.
  - A later read of 0x020 returns all 0x3C.
- Top block: read addr=0x7FF.
  - Base 0x7E0; data_out words 0xE0..0xFF.
  - With MEM_STATS_EN: rd_count increments by exactly 1.
- Reset mid-operation: write to 0x200 with data 0x77, then assert rst_n two cycles after acceptance.
  - No ready pulse.
  - After release, a read of 0x200 returns 0x00..0x1F (initial contents).
- Back-to-back: hold read=1 at addr 0x000 across the ready pulse.
  - A second ready arrives LATENCY+2 cycles after the first, with identical data.

Source files
------------

// File: rtl/mem_block_responder.sv
// mem_block_responder
//   Block-granular main-memory responder sitting at the far end of the L2
//   miss/writeback interface. A read or write request is accepted in IDLE,
//   held for a fixed access latency, then completed with a one-cycle ready
//   pulse (hit marks a completed read). The backing store is a byte array
//   that covers the whole address space. Reset loads it with word i = i mod
//   2^DATA_WIDTH.
//
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous reset, active-high (legacy name)
//     read      in   read request (level)
//     write     in   write request (level), has priority over read
//     addr      in   byte address; the block-offset bits are ignored
//     data_in   in   write block, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//     data_out  out  last read block, same packing
//     ready     out  one-cycle completion pulse
//     hit       out  high with ready when the completed op was a read
//
//   Optional build macro MEM_STATS_EN adds two outputs:
//     rd_count  out  saturating count of completed reads
//     wr_count  out  saturating count of completed writes
module mem_block_responder #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_SIZE = 32,
    parameter int LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             read,
    input  logic                             write,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_in,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             ready,
    output logic                             hit
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]                      rd_count,
    output logic [31:0]                      wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BW    = BLOCK_SIZE * DATA_WIDTH;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_is_read;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [BW-1:0]         r_wdata;
    logic [BW-1:0]         r_data_out;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_base;

    // Clearing the offset bits keeps every block inside the store, so
    // base+k never wraps.
    assign w_base = addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_read  <= 1'b0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_WIDTH'(i);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (write || read) begin
                        r_is_read <= ~write;
                        r_base    <= w_base;
                        r_wdata   <= data_in;
                        r_cnt     <= CNT_W'(LATENCY - 1);
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        // The store is touched only here, so a reset during
                        // BUSY discards a pending write.
                        if (r_is_read) begin
                            for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
                                r_data_out[k*DATA_WIDTH +: DATA_WIDTH] <=
                                    r_mem[r_base + ADDR_WIDTH'(k)];
                            end
                        end else begin
                            for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
                                r_mem[r_base + ADDR_WIDTH'(k)] <=
                                    r_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign ready    = (r_state == RESP);
    assign hit      = (r_state == RESP) && r_is_read;

`ifdef MEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == RESP) begin
            if (r_is_read) begin
                if (r_rd_count != '1) r_rd_count <= r_rd_count + 32'd1;
            end else begin
                if (r_wr_count != '1) r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule
